// File: rtl/wb_trace_fifo.sv
// Writeback trace capture: buffers non-$zero register writes from the core in a FWFT FIFO.
// Latency: an entry written at edge N is visible on rd_* with rd_valid=1 right after edge N.
// Backpressure: rd_ready paces the reader; writes arriving while full (and no pop) are dropped and counted.
//
// Ports:
//   clk, rst (async, active low), clear (sync flush of FIFO and overflow_cnt)
//   wb_valid/wb_pc/wb_addr/wb_data : writeback sample from the core, taken every cycle
//   rd_valid/rd_ready/rd_pc/rd_addr/rd_data : head-of-queue valid/ready read port
//   count (0..DEPTH), full, overflow_cnt (saturating count of dropped writes)
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int OVF_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wb_valid,
  input  logic [PC_W-1:0]          wb_pc,
  input  logic [4:0]               wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [PC_W-1:0]          rd_pc,
  output logic [4:0]               rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [OVF_W-1:0]         overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [OVF_W-1:0] OVF_ONE = 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      head;
  entry_t      last_q;   // most recently popped entry, shown on rd_* while empty
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        cap;
  logic        pop;
  logic        push;
  logic        drop;

  // Pointers carry one extra bit so equal indices can be told apart as full vs empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign rd_valid = !empty;

  assign cap  = wb_valid && (wb_addr != 5'd0);
  assign pop  = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  assign head = mem[rd_ptr[AW-1:0]];
  assign {rd_pc, rd_addr, rd_data} = empty ? last_q : head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_cnt <= '0;
      last_q       <= '0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        last_q <= head;
      end
      if (drop && (overflow_cnt != '1)) begin
        overflow_cnt <= overflow_cnt + OVF_ONE;
      end
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr[AW-1:0]] <= '{pc: wb_pc, addr: wb_addr, data: wb_data};
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
module tb_wb_trace_fifo;
  localparam int DEPTH   = 16;
  localparam int PC_W    = 32;
  localparam int DATA_W  = 32;
  localparam int OVF_W   = 4;
  localparam int OVF_MAX = (1 << OVF_W) - 1;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              wb_valid;
  logic [PC_W-1:0]   wb_pc;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic [4:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [CW-1:0]     count;
  logic              full;
  logic [OVF_W-1:0]  overflow_cnt;

  wb_trace_fifo #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W), .OVF_W(OVF_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .full(full), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: a queue of accepted writes, the last popped entry, and a drop count.
  ent_t q[$];
  ent_t last;
  int   ovf;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    last = '{pc: '0, addr: '0, data: '0};
    ovf  = 0;
  endtask

  task automatic check_outputs();
    chk("rd_valid", {63'd0, rd_valid}, {63'd0, q.size() != 0});
    chk("count", 64'(count), 64'(q.size()));
    chk("full", {63'd0, full}, {63'd0, q.size() == DEPTH});
    chk("overflow_cnt", 64'(overflow_cnt), 64'(ovf));
    if (q.size() != 0) begin
      chk("head_pc", 64'(rd_pc), 64'(q[0].pc));
      chk("head_addr", 64'(rd_addr), 64'(q[0].addr));
      chk("head_data", 64'(rd_data), 64'(q[0].data));
    end else begin
      chk("idle_pc", 64'(rd_pc), 64'(last.pc));
      chk("idle_addr", 64'(rd_addr), 64'(last.addr));
      chk("idle_data", 64'(rd_data), 64'(last.data));
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, then compare.
  task automatic step(input bit v, input logic [PC_W-1:0] pc, input logic [4:0] a,
                      input logic [DATA_W-1:0] d, input bit rdy, input bit clr);
    bit was_full;
    bit do_pop;
    bit do_cap;
    wb_valid = v; wb_pc = pc; wb_addr = a; wb_data = d; rd_ready = rdy; clear = clr;
    was_full = (q.size() == DEPTH);
    do_pop   = (q.size() != 0) && rdy;
    do_cap   = v && (a != 5'd0);
    if (clr) begin
      q.delete();
      ovf = 0;
    end else begin
      if (do_pop) last = q.pop_front();
      if (do_cap) begin
        if (!was_full || do_pop) q.push_back('{pc: pc, addr: a, data: d});
        else if (ovf < OVF_MAX) ovf++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, 5'd0, '0, rdy, 1'b0);
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d7[7];
    logic [PC_W-1:0] first_pc;
    d7 = '{535, 461, 722, 348, 187, 40, 495};

    rst = 1'b1; clear = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_addr = '0; wb_data = '0; rd_ready = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #2;
    check_outputs();
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    // Single capture visible on the next cycle.
    step(1'b1, 32'h0, 5'd4, 32'd535, 1'b0, 1'b0);
    chk("single_valid", {63'd0, rd_valid}, 64'd1);
    chk("single_addr", 64'(rd_addr), 64'd4);
    chk("single_data", 64'(rd_data), 64'd535);
    chk("single_count", 64'(count), 64'd1);
    idle(1'b1);

    // Seven captures, then drain in order.
    for (int i = 0; i < 7; i++) step(1'b1, 32'(4 * i), 5'd4, 32'(d7[i]), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      chk("drain_order", 64'(rd_data), 64'(d7[i]));
      idle(1'b1);
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", {63'd0, rd_valid}, 64'd0);

    // Writes to $zero are ignored.
    step(1'b1, 32'h100, 5'd0, 32'h1234, 1'b0, 1'b0);
    chk("zero_count", 64'(count), 64'd0);
    chk("zero_ovf", 64'(overflow_cnt), 64'd0);

    // Overfill by three.
    first_pc = 32'h1000;
    for (int i = 0; i < DEPTH + 3; i++)
      step(1'b1, first_pc + 32'(4 * i), 5'(1 + i % 31), $urandom, 1'b0, 1'b0);
    chk("ovf_full", {63'd0, full}, 64'd1);
    chk("ovf_count", 64'(count), 64'(DEPTH));
    chk("ovf_cnt3", 64'(overflow_cnt), 64'd3);
    chk("ovf_head", 64'(rd_pc), 64'(first_pc));

    // Full with simultaneous capture and pop: accepted, count holds.
    step(1'b1, 32'hABC, 5'd7, 32'hBEEF, 1'b1, 1'b0);
    chk("fullpop_count", 64'(count), 64'(DEPTH));
    chk("fullpop_ovf", 64'(overflow_cnt), 64'd3);

    // Keep dropping until the counter saturates.
    for (int i = 0; i < OVF_MAX + 4; i++) step(1'b1, 32'(i), 5'd9, $urandom, 1'b0, 1'b0);
    chk("ovf_sat", 64'(overflow_cnt), 64'(OVF_MAX));

    // Drain to five entries, then clear (with a capture in the same cycle).
    while (q.size() > 5) idle(1'b1);
    chk("pre_clear_count", 64'(count), 64'd5);
    step(1'b1, 32'h55, 5'd3, 32'h77, 1'b1, 1'b1);
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_ovf", 64'(overflow_cnt), 64'd0);

    // Pointer wrap: many writes interleaved with pops, never full.
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      bit rdy;
      rdy = (q.size() >= DEPTH - 2) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'b1, $urandom, 5'($urandom_range(1, 31)), $urandom, rdy, 1'b0);
    end
    while (q.size() > 0) idle(1'b1);
    chk("wrap_ovf", 64'(overflow_cnt), 64'd0);

    // Random traffic including $zero writes, overflows and occasional clears.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(i), 5'd5, $urandom, 1'b0, 1'b0);
    wb_valid = 1'b0; rd_ready = 1'b0; clear = 1'b0;
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", {63'd0, rd_valid}, 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_data", 64'(rd_data), 64'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
    step(1'b1, 32'h2000, 5'd6, 32'd99, 1'b0, 1'b0);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
